// File: rtl/pcu_restore_ctrl.sv
// Restore sequencer: drains the backup buffer one {data, addr} entry per
// three cycles (POP, LATCH, WRITE) and drives a one-hot restore to the addressed wrapper.
module pcu_restore_ctrl #(
  parameter  int K      = 10,
  parameter  int N      = 32,
  localparam int LOG2_K = $clog2(K)
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Pwr_off,
  input  logic                Start_Restore,
  input  logic                IsEmpty_Buffer,
  input  logic [N+LOG2_K-1:0] PopVal_Buffer,
  output logic                PopEn_Buffer,
  output logic [N-1:0]        Restore_Vin,
  output logic [K-1:0]        Restore_Ens,
  output logic [K-1:0]        Restored,
  output logic                Busy,
  output logic                Done,
  output logic                Err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LATCH,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      data_q, data_d;
  logic [LOG2_K-1:0] addr_q, addr_d;
  logic [K-1:0]      restored_q, restored_d;

  logic [N-1:0]      pop_data;
  logic [LOG2_K-1:0] pop_addr;
  logic              pop_addr_oob;
  logic [K-1:0]      addr_onehot;

  assign pop_data     = PopVal_Buffer[N+LOG2_K-1:LOG2_K];
  assign pop_addr     = PopVal_Buffer[LOG2_K-1:0];
  // Widened by one bit so the range check also works when K is a power of two.
  assign pop_addr_oob = ({1'b0, pop_addr} >= (LOG2_K+1)'(K));

  always_comb begin
    addr_onehot = '0;
    for (int unsigned i = 0; i < K; i++) begin
      addr_onehot[i] = (addr_q == LOG2_K'(i));
    end
  end

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    addr_d       = addr_q;
    restored_d   = restored_q;
    PopEn_Buffer = 1'b0;
    Busy         = 1'b0;
    Done         = 1'b0;
    Err          = 1'b0;
    Restore_Ens  = '0;
    Restore_Vin  = '0;
    case (state_q)
      S_IDLE: begin
        if (Start_Restore) begin
          restored_d = '0;
          state_d    = IsEmpty_Buffer ? S_DONE : S_POP;
        end
      end
      S_POP: begin
        PopEn_Buffer = 1'b1;
        Busy         = 1'b1;
        state_d      = S_LATCH;
      end
      S_LATCH: begin
        Busy    = 1'b1;
        data_d  = pop_data;
        addr_d  = pop_addr;
        state_d = pop_addr_oob ? S_ERR : S_WRITE;
      end
      S_WRITE: begin
        Busy        = 1'b1;
        Restore_Ens = addr_onehot;
        Restore_Vin = data_q;
        restored_d  = restored_q | addr_onehot;
        state_d     = IsEmpty_Buffer ? S_DONE : S_POP;
      end
      S_DONE: begin
        Done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        Err = 1'b1;
        if (Start_Restore) begin
          restored_d = '0;
          state_d    = IsEmpty_Buffer ? S_DONE : S_POP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign Restored = restored_q;

  always_ff @(posedge Clk) begin
    if (!Rst || Pwr_off) begin
      state_q    <= S_IDLE;
      data_q     <= '0;
      addr_q     <= '0;
      restored_q <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      restored_q <= restored_d;
    end
  end

endmodule

// File: tb/tb_pcu_restore_ctrl.sv
// Directed self-checking bench for pcu_restore_ctrl (K=10, N=32) with a
// one-cycle-latency buffer model; inputs change and outputs are sampled on negedge.
module tb_pcu_restore_ctrl;

  localparam int K      = 10;
  localparam int N      = 32;
  localparam int LOG2_K = $clog2(K);
  localparam int W      = N + LOG2_K;

  logic         clk = 1'b0;
  logic         rst;
  logic         pwr_off;
  logic         start;
  logic         is_empty;
  logic [W-1:0] pop_val;
  logic         pop_en;
  logic [N-1:0] vin;
  logic [K-1:0] ens;
  logic [K-1:0] restored;
  logic         busy;
  logic         done;
  logic         err;

  always #5 clk = ~clk;

  pcu_restore_ctrl #(.K(K), .N(N)) dut (
    .Clk            (clk),
    .Rst            (rst),
    .Pwr_off        (pwr_off),
    .Start_Restore  (start),
    .IsEmpty_Buffer (is_empty),
    .PopVal_Buffer  (pop_val),
    .PopEn_Buffer   (pop_en),
    .Restore_Vin    (vin),
    .Restore_Ens    (ens),
    .Restored       (restored),
    .Busy           (busy),
    .Done           (done),
    .Err            (err)
  );

  // Buffer model: a pop seen in cycle t presents its entry for cycle t+1.
  logic [W-1:0] buf_q[$];
  always @(negedge clk) begin
    if (pop_en) begin
      if (buf_q.size() > 0) pop_val = buf_q.pop_front();
      is_empty = (buf_q.size() == 0);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq(tag, {pop_en, busy, done, err, ens, vin, restored}, 64'd0);
  endtask

  task automatic load(input logic [N-1:0] data, input logic [LOG2_K-1:0] addr);
    buf_q.push_back({data, addr});
    is_empty = 1'b0;
  endtask

  int           n_pops;
  int           first_pop;
  int           done_cyc;
  int           err_cyc;
  logic         busy_seen;
  logic [K-1:0] wr_ens[$];
  logic [N-1:0] wr_vin[$];
  int           wr_cyc[$];

  // Pulses Start for one cycle and logs activity until Done or a settled Err.
  task automatic run_restore(input int max_cyc);
    n_pops = 0; first_pop = -1; done_cyc = -1; err_cyc = -1; busy_seen = 1'b0;
    wr_ens.delete(); wr_vin.delete(); wr_cyc.delete();
    start = 1'b1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (pop_en) begin
        n_pops++;
        if (first_pop < 0) first_pop = c;
      end
      if (ens != '0) begin
        wr_ens.push_back(ens);
        wr_vin.push_back(vin);
        wr_cyc.push_back(c);
      end
      if (busy) busy_seen = 1'b1;
      if (err && err_cyc < 0) err_cyc = c;
      if (done) begin
        done_cyc = c;
        break;
      end
      if (err_cyc > 0 && c >= err_cyc + 3) break;
    end
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [K-1:0] e,
                          input logic [N-1:0] v, input int cyc);
    check_eq({tag, "_ens"}, wr_ens[idx], e);
    check_eq({tag, "_vin"}, wr_vin[idx], v);
    check_eq({tag, "_cyc"}, wr_cyc[idx], cyc);
  endtask

  initial begin
    rst = 1'b0; pwr_off = 1'b0; start = 1'b1; pop_val = '0; is_empty = 1'b1;
    load(32'h1111_1111, 4'd1);

    // Reset held with Start and a non-empty buffer
    repeat (2) begin
      @(negedge clk);
      check_zero("reset_outputs");
    end
    rst = 1'b1;
    run_restore(30);
    check_eq("rst_first_pop", first_pop, 1);
    check_eq("rst_pops", n_pops, 1);
    check_eq("rst_nwr", wr_ens.size(), 1);
    check_wr("rst_wr0", 0, 10'h002, 32'h1111_1111, 3);
    check_eq("rst_done", done_cyc, 4);

    // Three-entry drain
    load(32'hDEAD_BEEF, 4'd3);
    load(32'h1234_5678, 4'd0);
    load(32'hCAFE_F00D, 4'd9);
    @(negedge clk);
    run_restore(40);
    check_eq("drain_pops", n_pops, 3);
    check_eq("drain_nwr", wr_ens.size(), 3);
    check_wr("drain_wr0", 0, 10'h008, 32'hDEAD_BEEF, 3);
    check_wr("drain_wr1", 1, 10'h001, 32'h1234_5678, 6);
    check_wr("drain_wr2", 2, 10'h200, 32'hCAFE_F00D, 9);
    check_eq("drain_done", done_cyc, 10);
    check_eq("drain_restored", restored, 10'h209);
    check_eq("drain_err", err_cyc, -1);
    @(negedge clk);
    check_eq("drain_idle_busy_done", {busy, done}, 2'b00);
    check_eq("drain_restored_held", restored, 10'h209);

    // Empty start clears Restored and completes immediately
    run_restore(10);
    check_eq("empty_done", done_cyc, 1);
    check_eq("empty_pops", n_pops, 0);
    check_eq("empty_busy_seen", busy_seen, 1'b0);
    check_eq("empty_restored", restored, 10'h000);

    // Out-of-range address on the second entry
    load(32'h1111_2222, 4'd4);
    load(32'h3333_4444, 4'd12);
    load(32'h5555_6666, 4'd1);
    @(negedge clk);
    run_restore(40);
    check_eq("bad_nwr", wr_ens.size(), 1);
    check_wr("bad_wr0", 0, 10'h010, 32'h1111_2222, 3);
    check_eq("bad_err_cyc", err_cyc, 6);
    check_eq("bad_pops", n_pops, 2);
    check_eq("bad_done", done_cyc, -1);
    check_eq("bad_err_level", {err, busy, pop_en, ens}, {1'b1, 1'b0, 1'b0, 10'h000});
    check_eq("bad_restored_held", restored, 10'h010);
    run_restore(20);
    check_eq("bad_restart_err", err_cyc, -1);
    check_eq("bad_restart_nwr", wr_ens.size(), 1);
    check_wr("bad_restart_wr0", 0, 10'h002, 32'h5555_6666, 3);
    check_eq("bad_restart_done", done_cyc, 4);
    check_eq("bad_restart_restored", restored, 10'h002);

    // Duplicate address, later entry wins
    load(32'hAAAA_0000, 4'd5);
    load(32'hBBBB_0000, 4'd5);
    @(negedge clk);
    run_restore(30);
    check_eq("dup_nwr", wr_ens.size(), 2);
    check_wr("dup_wr0", 0, 10'h020, 32'hAAAA_0000, 3);
    check_wr("dup_wr1", 1, 10'h020, 32'hBBBB_0000, 6);
    check_eq("dup_done", done_cyc, 7);
    check_eq("dup_restored", restored, 10'h020);

    // Pwr_off during LATCH of entry 2
    load(32'h0102_0304, 4'd2);
    load(32'h0506_0708, 4'd7);
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 3) check_eq("pwr_wr0_ens", ens, 10'h004);
    end
    check_eq("pwr_latch_state", {busy, pop_en, ens}, {1'b1, 1'b0, 10'h000});
    pwr_off = 1'b1;
    start   = 1'b1;
    @(negedge clk);
    check_zero("pwr_off_outputs");
    @(negedge clk);
    check_zero("pwr_off_start_ignored");
    pwr_off = 1'b0;
    start   = 1'b0;
    buf_q.delete();
    is_empty = 1'b1;
    @(negedge clk);
    check_zero("pwr_off_released");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
